uart_loopback_bist: RTL and testbench
=====================================

// Module: uart_loopback_bist
// PURPOSE
//  Synthesizable built-in self-test for the UART core. Streams BURST_LEN pattern words into the UART
//  TX AXI-Stream slave and checks words returning on the UART RX AXI-Stream master (tx looped to rx).
//  Counts sent, received and mismatched words, and flags parity errors and a loss-of-data timeout.
//  Sits beside the UART core so loopback regression runs on silicon and in simulation.
// PARAMETERS
//  DATA_BITS     8      word width, 5..9, matches the UART data_bits setting
//  CNT_W         16     width of burst_len and all counters
//  MAX_OUTST     16     max words in flight (TX accepted minus RX received); set to UART fifo_deepth
//  TIMEOUT_CYC   65536  clocks without an RX beat while words are outstanding before abort
//  SEED          16'hACE1  pattern start value; 0 is replaced by 16'hACE1 in PRBS mode
// PORTS
//  clk            in   1          system clock
//  rst_n          in   1          reset, asynchronous, active-high
//  start          in   1          one-cycle pulse, starts a run; ignored while busy
//  mode           in   1          0 = incrementing pattern, 1 = PRBS16; sampled at start
//  burst_len      in   CNT_W      words to send; sampled at start
//  m_axis_tdata   out  DATA_BITS  pattern word to UART TX
//  m_axis_tvalid  out  1          word valid
//  m_axis_tready  in   1          UART TX ready
//  s_axis_tdata   in   DATA_BITS  word from UART RX
//  s_axis_tvalid  in   1          RX word valid
//  s_axis_tready  out  1          always 1 (bist never stalls RX)
//  check_flag     in   1          UART parity error, qualified by s_axis_tvalid
//  busy           out  1          run in progress
//  done           out  1          run finished; held until next accepted start
//  pass           out  1          valid while done: rx_count==burst_len, err_count==0, no timeout, no parity error
//  timeout        out  1          run aborted by TIMEOUT_CYC
//  tx_count       out  CNT_W      words accepted by TX
//  rx_count       out  CNT_W      words received while busy
//  err_count      out  CNT_W      data mismatches plus parity-flagged words, saturates at all-ones
// BEHAVIOUR
//  - Reset: FSM IDLE; all outputs 0 except s_axis_tready=1; counters 0; both generators = seed.
//  - FSM IDLE -> RUN on start (latch mode, burst_len; clear counters, done, pass, timeout; reload both generators).
//    burst_len==0: IDLE -> DONE directly, pass=1 on the next cycle.
//    RUN -> DRAIN when tx_count reaches burst_len (cycle after last TX handshake).
//    DRAIN -> DONE when rx_count==burst_len. RUN/DRAIN -> DONE on timeout.
//    DONE -> RUN on start. busy=1 in RUN and DRAIN.
//  - TX: m_axis_tvalid=1 in RUN when outst<MAX_OUTST. First tvalid is asserted the cycle after start is sampled.
//    tdata holds stable until handshake; tx generator advances on each handshake.
//  - RX: beat = s_axis_tvalid in RUN/DRAIN. Compare s_axis_tdata with expected generator; mismatch or
//    check_flag -> err_count+1 (once per beat); expected generator advances every beat. Beats in IDLE/DONE are dropped.
//  - outst = tx_count - rx_count. A TX and an RX handshake in the same cycle leave it unchanged. An RX beat
//    with outst==0 (spurious) counts as an error and does not advance the expected generator.
//  - Timeout counter clears on every RX beat and whenever outst==0; abort when it reaches TIMEOUT_CYC-1.
//    On abort: timeout=1, pass=0, tvalid dropped.
//  - Pattern: incrementing = seed + n, mod 2^DATA_BITS. PRBS16 = Galois LFSR, mask 16'hB400, shift right;
//    word = low DATA_BITS bits.
//  - Counters wrap mod 2^CNT_W except err_count (saturates).
//  - Async reset mid-run returns to IDLE with no partial state; a UART word in flight is dropped (IDLE).
// STRUCTURE
//  - Package uart_bist_pkg: FSM state enum (IDLE, RUN, DRAIN, DONE), LFSR mask 16'hB400, default seed 16'hACE1.
//  - Sub-module uart_pattern_gen (mode, load, advance, word out): instanced twice, for TX and expected-RX.
//  - Top: FSM, counters, timeout, compare.
// TESTING
//  - Loopback through UART (50 MHz, 115200, 8 bits, odd parity, fifo 16), mode=0, burst_len=20, SEED=8'h00
//    -> TX words 0..19; done with pass=1; tx=rx=20, err=0.
//  - Same with mode=1, burst_len=300 -> first word 8'hE1; pass=1; tx=rx=300.
//  - Bench flips bit 0 of RX word #5 of 10 -> err_count=1, pass=0, rx_count=10.
//  - Bench holds m_axis_tready=1 and never returns RX, TIMEOUT_CYC=1000, burst_len=40
//    -> tx_count stops at 16 (MAX_OUTST); timeout=1 1000 cycles later; pass=0.
//  - burst_len=0 start -> done=1, pass=1 within 2 cycles; no tvalid. Second start while busy -> ignored.
//  - rst_n pulsed during RUN at word 7 -> all outputs at reset values next cycle; a new start with burst_len=5 passes.

Source files
------------

// File: rtl/uart_loopback_bist_pkg.sv
// Shared types and constants for the UART loopback built-in self-test.
package uart_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Galois LFSR step, shifting right with feedback taps from the mask.
  function automatic logic [15:0] lfsrNext(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/uart_loopback_bist_if.sv
// AXI-Stream style word channel between the BIST and the UART core; checkFlag carries RX parity errors.
interface uart_loopback_bist_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] tdata;
  logic                 tvalid;
  logic                 tready;
  logic                 checkFlag;

  modport master (
    output tdata,
    output tvalid,
    output checkFlag,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  checkFlag,
    output tready
  );

endinterface

// File: rtl/uart_loopback_bist_pattern_gen.sv
// Pattern generator: incrementing or PRBS16 word stream, reloaded on load and stepped on advance.
module uart_pattern_gen
  import uart_bist_pkg::*;
#(
  parameter int          DATA_BITS = 8,
  parameter logic [15:0] SEED      = DEFAULT_SEED
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode_i,
  input  logic                 load_i,
  input  logic                 advance_i,
  output logic [DATA_BITS-1:0] word_o
);

  logic [15:0] pattern_q, pattern_d;
  logic        mode_q, mode_d;

  // An all-zero LFSR would lock up, so PRBS mode substitutes the default seed.
  always_comb begin
    pattern_d = pattern_q;
    mode_d    = mode_q;
    if (load_i) begin
      mode_d    = mode_i;
      pattern_d = (mode_i && (SEED == 16'h0000)) ? DEFAULT_SEED : SEED;
    end else if (advance_i) begin
      pattern_d = mode_q ? lfsrNext(pattern_q) : pattern_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pattern_q <= SEED;
      mode_q    <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      mode_q    <= mode_d;
    end
  end

  assign word_o = pattern_q[DATA_BITS-1:0];

endmodule

// File: rtl/uart_loopback_bist.sv
// Loopback self-test: streams pattern words into UART TX, checks what comes back on UART RX.
module uart_loopback_bist
  import uart_bist_pkg::*;
#(
  parameter int          DATA_BITS   = 8,
  parameter int          CNT_W       = 16,
  parameter int          MAX_OUTST   = 16,
  parameter int          TIMEOUT_CYC = 65536,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic                      mode_i,
  input  logic [CNT_W-1:0]          burstLen_i,
  uart_loopback_bist_if.master      mAxis,
  uart_loopback_bist_if.slave       sAxis,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      pass_o,
  output logic                      timeout_o,
  output logic [CNT_W-1:0]          txCount_o,
  output logic [CNT_W-1:0]          rxCount_o,
  output logic [CNT_W-1:0]          errCount_o
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     burstLen_q, burstLen_d;
  logic [CNT_W-1:0]     txCount_q, txCount_d;
  logic [CNT_W-1:0]     rxCount_q, rxCount_d;
  logic [CNT_W-1:0]     errCount_q, errCount_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 timeout_q, timeout_d;
  logic                 parity_q, parity_d;

  logic                 active;
  logic                 genLoad;
  logic [CNT_W-1:0]     outst;
  logic                 txValid;
  logic                 txFire;
  logic                 rxBeat;
  logic                 rxSpurious;
  logic                 rxGood;
  logic                 rxErr;
  logic                 timeoutHit;
  logic [DATA_BITS-1:0] txWord;
  logic [DATA_BITS-1:0] rxExpected;

  assign active     = (state_q == RUN) || (state_q == DRAIN);
  assign outst      = txCount_q - rxCount_q;
  assign txValid    = (state_q == RUN) && (txCount_q != burstLen_q) && (outst < CNT_W'(MAX_OUTST));
  assign txFire     = txValid && mAxis.tready;
  assign rxBeat     = active && sAxis.tvalid;
  assign rxSpurious = rxBeat && (outst == '0);
  assign rxGood     = rxBeat && !rxSpurious;
  assign rxErr      = rxSpurious || (rxGood && ((sAxis.tdata != rxExpected) || sAxis.checkFlag));
  assign timeoutHit = active && (outst != '0) && !rxBeat && (timer_q == TW'(TIMEOUT_CYC - 1));

  uart_pattern_gen #(
    .DATA_BITS (DATA_BITS),
    .SEED      (SEED)
  ) txGen (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_i    (mode_i),
    .load_i    (genLoad),
    .advance_i (txFire),
    .word_o    (txWord)
  );

  uart_pattern_gen #(
    .DATA_BITS (DATA_BITS),
    .SEED      (SEED)
  ) rxGen (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_i    (mode_i),
    .load_i    (genLoad),
    .advance_i (rxGood),
    .word_o    (rxExpected)
  );

  // Counter updates first; the state case then overrides them on start or abort.
  always_comb begin
    state_d    = state_q;
    burstLen_d = burstLen_q;
    txCount_d  = txCount_q;
    rxCount_d  = rxCount_q;
    errCount_d = errCount_q;
    done_d     = done_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    parity_d   = parity_q;
    genLoad    = 1'b0;
    timer_d    = (!active || (outst == '0) || rxBeat) ? '0 : timer_q + 1'b1;

    if (txFire) begin
      txCount_d = txCount_q + 1'b1;
    end
    if (rxGood) begin
      rxCount_d = rxCount_q + 1'b1;
    end
    if (rxErr && !(&errCount_q)) begin
      errCount_d = errCount_q + 1'b1;
    end
    if (rxBeat && sAxis.checkFlag) begin
      parity_d = 1'b1;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          genLoad    = 1'b1;
          burstLen_d = burstLen_i;
          txCount_d  = '0;
          rxCount_d  = '0;
          errCount_d = '0;
          timer_d    = '0;
          parity_d   = 1'b0;
          timeout_d  = 1'b0;
          if (burstLen_i == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = RUN;
            done_d  = 1'b0;
            pass_d  = 1'b0;
          end
        end
      end
      RUN: begin
        if (timeoutHit) begin
          state_d   = DONE;
          done_d    = 1'b1;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
        end else if (txCount_q == burstLen_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (timeoutHit) begin
          state_d   = DONE;
          done_d    = 1'b1;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
        end else if (rxCount_q == burstLen_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (errCount_d == '0) && !parity_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= IDLE;
      burstLen_q <= '0;
      txCount_q  <= '0;
      rxCount_q  <= '0;
      errCount_q <= '0;
      timer_q    <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      parity_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      burstLen_q <= burstLen_d;
      txCount_q  <= txCount_d;
      rxCount_q  <= rxCount_d;
      errCount_q <= errCount_d;
      timer_q    <= timer_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      parity_q   <= parity_d;
    end
  end

  // TX data is gated so the idle bus reads as zero rather than the seed.
  assign mAxis.tvalid    = txValid;
  assign mAxis.tdata     = txValid ? txWord : '0;
  assign mAxis.checkFlag = 1'b0;
  assign sAxis.tready    = 1'b1;

  assign busy_o     = active;
  assign done_o     = done_q;
  assign pass_o     = pass_q;
  assign timeout_o  = timeout_q;
  assign txCount_o  = txCount_q;
  assign rxCount_o  = rxCount_q;
  assign errCount_o = errCount_q;

endmodule

// File: tb/tb_uart_loopback_bist.sv
// Bench for uart_loopback_bist: a queue-based loopback stands in for the UART, a pattern model supplies expected words.
module tb_uart_loopback_bist;

  localparam int          DATA_BITS   = 8;
  localparam int          CNT_W       = 16;
  localparam int          MAX_OUTST   = 16;
  localparam int          TIMEOUT_CYC = 1000;
  localparam logic [15:0] SEED        = 16'h0000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             mode;
  logic [CNT_W-1:0] burstLen;
  logic             busy, done, pass, timeoutO;
  logic [CNT_W-1:0] txCount, rxCount, errCount;

  uart_loopback_bist_if #(.DATA_BITS(DATA_BITS)) txIf ();
  uart_loopback_bist_if #(.DATA_BITS(DATA_BITS)) rxIf ();

  always #5 clk = ~clk;

  uart_loopback_bist #(
    .DATA_BITS   (DATA_BITS),
    .CNT_W       (CNT_W),
    .MAX_OUTST   (MAX_OUTST),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SEED        (SEED)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .mode_i     (mode),
    .burstLen_i (burstLen),
    .mAxis      (txIf),
    .sAxis      (rxIf),
    .busy_o     (busy),
    .done_o     (done),
    .pass_o     (pass),
    .timeout_o  (timeoutO),
    .txCount_o  (txCount),
    .rxCount_o  (rxCount),
    .errCount_o (errCount)
  );

  int         testCount  = 0;
  int         failCount  = 0;
  logic [7:0] expQ[$];
  logic [8:0] loopQ[$];
  int         txIndex    = 0;
  int         corruptIdx = -1;
  int         flagIdx    = -1;
  bit         loopEnable = 1'b1;
  bit         forceReady = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Expected word stream: seed+n for the incrementing pattern, successive LFSR states for PRBS.
  task automatic buildExpected(input bit m, input int len);
    logic [15:0] s;
    expQ.delete();
    s = (m && SEED == 16'h0000) ? 16'hACE1 : SEED;
    for (int n = 0; n < len; n++) begin
      if (!m) begin
        expQ.push_back(8'((int'(SEED) + n) % 256));
      end else begin
        expQ.push_back(s[7:0]);
        s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
      end
    end
  endtask

  task automatic applyStimulus(input bit m, input int len);
    @(negedge clk);
    buildExpected(m, len);
    txIndex  = 0;
    mode     = m;
    burstLen = CNT_W'(len);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, ".doneReached"}, 32'(done === 1'b1), 1);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, ".busy"},     busy,         0);
    checkOutput({tag, ".done"},     done,         0);
    checkOutput({tag, ".pass"},     pass,         0);
    checkOutput({tag, ".timeout"},  timeoutO,     0);
    checkOutput({tag, ".txCount"},  txCount,      0);
    checkOutput({tag, ".rxCount"},  rxCount,      0);
    checkOutput({tag, ".errCount"}, errCount,     0);
    checkOutput({tag, ".tvalid"},   txIf.tvalid,  0);
    checkOutput({tag, ".tdata"},    txIf.tdata,   0);
    checkOutput({tag, ".rxReady"},  rxIf.tready,  1);
  endtask

  task automatic runAndCheck(input string tag, input bit m, input int len, input int cIdx, input int fIdx);
    int cycles;
    int expErr;
    corruptIdx = cIdx;
    flagIdx    = fIdx;
    expErr     = ((cIdx >= 0 && cIdx < len) ? 1 : 0) +
                 ((fIdx >= 0 && fIdx < len && fIdx != cIdx) ? 1 : 0);
    applyStimulus(m, len);
    checkOutput({tag, ".busyAfterStart"}, busy,        1);
    checkOutput({tag, ".doneCleared"},    done,        0);
    checkOutput({tag, ".firstValid"},     txIf.tvalid, 1);
    checkOutput({tag, ".firstWord"},      txIf.tdata,  expQ[0]);
    waitDone(tag, 8000, cycles);
    checkOutput({tag, ".txCount"},  txCount,  len);
    checkOutput({tag, ".rxCount"},  rxCount,  len);
    checkOutput({tag, ".errCount"}, errCount, expErr);
    checkOutput({tag, ".pass"},     pass,     32'(expErr == 0));
    checkOutput({tag, ".timeout"},  timeoutO, 0);
    checkOutput({tag, ".busyEnd"},  busy,     0);
    corruptIdx = -1;
    flagIdx    = -1;
  endtask

  // UART stand-in: accepted TX words are queued (optionally corrupted) and replayed on RX at random pace.
  initial begin
    logic       th;
    logic       rh;
    logic [7:0] tw;
    logic [8:0] e;
    txIf.tready    = 1'b0;
    rxIf.tvalid    = 1'b0;
    rxIf.tdata     = '0;
    rxIf.checkFlag = 1'b0;
    forever begin
      @(negedge clk);
      th = txIf.tvalid && txIf.tready && !rst_n;
      tw = txIf.tdata;
      rh = rxIf.tvalid && rxIf.tready;
      @(posedge clk);
      #1;
      if (rh && loopQ.size() > 0) void'(loopQ.pop_front());
      if (th) begin
        checkOutput("txIndexInRange", 32'(txIndex < expQ.size()), 1);
        if (txIndex < expQ.size()) checkOutput("txWord", tw, expQ[txIndex]);
        e = {1'b0, tw};
        if (txIndex == corruptIdx) e[0] = ~e[0];
        if (txIndex == flagIdx) e[8] = 1'b1;
        if (loopEnable) loopQ.push_back(e);
        txIndex++;
      end
      txIf.tready = forceReady ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (loopQ.size() > 0 && $urandom_range(0, 9) < 7) begin
        rxIf.tvalid    = 1'b1;
        rxIf.tdata     = loopQ[0][7:0];
        rxIf.checkFlag = loopQ[0][8];
      end else begin
        rxIf.tvalid    = 1'b0;
        rxIf.tdata     = '0;
        rxIf.checkFlag = 1'b0;
      end
    end
  end

  initial begin
    int cycles;
    int n;
    bit m;
    int len;
    int c;
    int f;
    rst_n    = 1'b1;
    start    = 1'b0;
    mode     = 1'b0;
    burstLen = '0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    runAndCheck("inc20",    1'b0, 20,  -1, -1);
    runAndCheck("prbs300",  1'b1, 300, -1, -1);
    runAndCheck("corrupt5", 1'b0, 10,  5,  -1);
    runAndCheck("parity3",  1'b1, 12,  -1, 3);

    for (int r = 0; r < 3; r++) begin
      m   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 60));
      c   = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, len - 1)) : -1;
      f   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      runAndCheck($sformatf("rand%0d", r), m, len, c, f);
    end

    applyStimulus(1'b0, 0);
    checkOutput("zero.done",    done,        1);
    checkOutput("zero.pass",    pass,        1);
    checkOutput("zero.busy",    busy,        0);
    checkOutput("zero.tvalid",  txIf.tvalid, 0);
    @(negedge clk);
    checkOutput("zero.tvalid2", txIf.tvalid, 0);
    checkOutput("zero.txCount", txCount,     0);

    applyStimulus(1'b0, 10);
    repeat (3) @(negedge clk);
    mode     = 1'b1;
    burstLen = 16'd3;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    checkOutput("ignored.busy", busy, 1);
    waitDone("ignored", 4000, cycles);
    checkOutput("ignored.txCount", txCount, 10);
    checkOutput("ignored.rxCount", rxCount, 10);
    checkOutput("ignored.pass",    pass,    1);

    loopEnable = 1'b0;
    forceReady = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 40);
    n = 0;
    while (txCount == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeout.firstTx", txCount, 1);
    waitDone("timeout", 3000, cycles);
    checkOutput("timeout.txCount", txCount,  MAX_OUTST);
    checkOutput("timeout.flag",    timeoutO, 1);
    checkOutput("timeout.pass",    pass,     0);
    checkOutput("timeout.latency", 32'(cycles >= TIMEOUT_CYC - 2 && cycles <= TIMEOUT_CYC + 2), 1);
    loopEnable = 1'b1;
    forceReady = 1'b0;
    repeat (2) @(negedge clk);

    applyStimulus(1'b0, 20);
    n = 0;
    while (txCount != 7 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midReset.reached7", txCount, 7);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    loopQ.delete();
    @(negedge clk);
    checkIdleOutputs("midReset");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    runAndCheck("afterReset", 1'b0, 5, -1, -1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
